// File: rtl/vend_change_fsm.sv
// Coin-operated vending controller: accumulates credit, releases one product
// per purchase and holds any change until the payout mechanism acknowledges.
module vend_change_fsm #(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 40,
    parameter int CREDIT_W   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin5,
    input  logic                coin10,
    input  logic                coin25,
    input  logic                cancel,
    input  logic                change_ack,
    output logic                dispense,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   V5      = (CREDIT_W+1)'(5);
    localparam logic [CREDIT_W:0]   V10     = (CREDIT_W+1)'(10);
    localparam logic [CREDIT_W:0]   V25     = (CREDIT_W+1)'(25);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                coin_reject_q, coin_reject_d;

    logic                any_coin;
    logic                one_coin;
    logic                accept;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;

    always_comb begin
        coin_val = '0;
        one_coin = 1'b0;
        unique case ({coin25, coin10, coin5})
            3'b001: begin coin_val = V5;  one_coin = 1'b1; end
            3'b010: begin coin_val = V10; one_coin = 1'b1; end
            3'b100: begin coin_val = V25; one_coin = 1'b1; end
            default: begin coin_val = '0; one_coin = 1'b0; end
        endcase
    end

    // Sum is one bit wider than credit so an overflow check never wraps.
    assign any_coin = coin5 | coin10 | coin25;
    assign sum      = {1'b0, credit_q} + coin_val;
    assign accept   = ((state_q == IDLE) || (state_q == CREDIT)) &&
                      one_coin && !cancel && (sum <= MAX_X);

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = any_coin && !accept;
        unique case (state_q)
            IDLE, CREDIT: begin
                if (accept) begin
                    credit_d = sum[CREDIT_W-1:0];
                    state_d  = (sum >= PRICE_X) ? VEND : CREDIT;
                end else if (cancel && state_q == CREDIT) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_q > PRICE_C) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (change_ack) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    // Outputs decode straight from flops so reset clears them immediately.
    assign dispense     = (state_q == VEND);
    assign change_valid = (state_q == CHANGE);
    assign change_amt   = (state_q == CHANGE) ? credit_q : '0;
    assign credit       = credit_q;
    assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vend_change_fsm.sv
// Directed bench for vend_change_fsm at PRICE=15, MAX_CREDIT=40.
// Observed word: {dispense, change_valid, change_amt, credit, coin_reject}.
module tb_vend_change_fsm;

    logic       clk;
    logic       rst_n;
    logic       coin5, coin10, coin25, cancel, change_ack;
    logic       dispense, change_valid, coin_reject;
    logic [5:0] change_amt, credit;
    logic [14:0] obs;
    logic [14:0] want;

    int vectors;
    int miscompares;

    vend_change_fsm #(.PRICE(15), .MAX_CREDIT(40), .CREDIT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin5        (coin5),
        .coin10       (coin10),
        .coin25       (coin25),
        .cancel       (cancel),
        .change_ack   (change_ack),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .credit       (credit),
        .coin_reject  (coin_reject)
    );

    assign obs = {dispense, change_valid, change_amt, credit, coin_reject};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ex(bit d, bit v, int a, int c, bit r);
        logic [5:0] a6;
        logic [5:0] c6;
        a6 = 6'(a);
        c6 = 6'(c);
        return {d, v, a6, c6, r};
    endfunction

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(bit c5, bit c10, bit c25, bit cn, bit ack);
        coin5 = c5; coin10 = c10; coin25 = c25;
        cancel = cn; change_ack = ack;
        @(posedge clk);
        #1;
        coin5 = 0; coin10 = 0; coin25 = 0;
        cancel = 0; change_ack = 0;
    endtask

    task automatic test_reset();
        #1;
        want = ex(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL reset_initial got %h want %h", obs, want);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        step(0, 0, 1, 0, 0);
        want = ex(1, 0, 0, 25, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL reset_pre_vend got %h want %h", obs, want);
        end
        #2 rst_n = 0;
        #1;
        want = ex(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL reset_async_vend got %h want %h", obs, want);
        end
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        want = ex(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL reset_async_change got %h want %h", obs, want);
        end
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 0, 0, 0);
        want = ex(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL reset_release got %h want %h", obs, want);
        end
    endtask

    task automatic test_exact_price();
        step(1, 0, 0, 0, 0);
        want = ex(0, 0, 0, 5, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL exact_c5 got %h want %h", obs, want);
        end
        step(0, 1, 0, 0, 0);
        want = ex(1, 0, 0, 15, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL exact_vend got %h want %h", obs, want);
        end
        step(0, 0, 0, 0, 0);
        want = ex(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL exact_idle got %h want %h", obs, want);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL exact_idle2 got %h want %h", obs, want);
        end
    endtask

    task automatic test_change_hold();
        step(0, 0, 1, 0, 0);
        want = ex(1, 0, 0, 25, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL c25_vend got %h want %h", obs, want);
        end
        step(0, 0, 0, 0, 0);
        want = ex(0, 1, 10, 10, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL c25_change got %h want %h", obs, want);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL c25_hold%0d got %h want %h", i, obs, want);
            end
        end
        step(0, 0, 0, 0, 1);
        want = ex(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL c25_ack got %h want %h", obs, want);
        end
    endtask

    task automatic test_cancel();
        step(0, 1, 0, 0, 0);
        want = ex(0, 0, 0, 10, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL cancel_c10 got %h want %h", obs, want);
        end
        step(0, 0, 0, 1, 0);
        want = ex(0, 1, 10, 10, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL cancel_change got %h want %h", obs, want);
        end
        step(0, 0, 0, 0, 1);
        want = ex(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL cancel_ack got %h want %h", obs, want);
        end
    endtask

    task automatic test_reject();
        step(1, 1, 0, 0, 0);
        want = ex(0, 0, 0, 0, 1);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL rej_multi got %h want %h", obs, want);
        end
        step(0, 0, 0, 0, 0);
        want = ex(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL rej_multi_clear got %h want %h", obs, want);
        end
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        want = ex(0, 1, 10, 10, 1);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL rej_change got %h want %h", obs, want);
        end
        step(0, 0, 0, 0, 0);
        want = ex(0, 1, 10, 10, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL rej_change_clear got %h want %h", obs, want);
        end
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        want = ex(0, 1, 5, 5, 1);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL rej_cancel got %h want %h", obs, want);
        end
        step(0, 0, 0, 0, 0);
        want = ex(0, 1, 5, 5, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL rej_cancel_clear got %h want %h", obs, want);
        end
        step(0, 0, 0, 0, 1);
        want = ex(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL rej_cancel_ack got %h want %h", obs, want);
        end
    endtask

    task automatic test_idle_ignore();
        step(0, 0, 0, 0, 1);
        want = ex(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL idle_ack got %h want %h", obs, want);
        end
        step(0, 0, 0, 1, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL idle_cancel got %h want %h", obs, want);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        want = ex(1, 0, 0, 20, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL b2b_vend got %h want %h", obs, want);
        end
        step(0, 0, 1, 1, 0);
        want = ex(0, 1, 5, 5, 1);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL b2b_vend_coin got %h want %h", obs, want);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        want = ex(1, 0, 0, 25, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL b2b_second got %h want %h", obs, want);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        want = ex(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL b2b_done got %h want %h", obs, want);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 0;
        coin5 = 0; coin10 = 0; coin25 = 0;
        cancel = 0; change_ack = 0;
        test_reset();
        test_exact_price();
        test_change_hold();
        test_cancel();
        test_reject();
        test_idle_ignore();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vend_change_fsm.md
VEND_CHANGE_FSM -- requirements
Module: vend_change_fsm

Interface
REQ-001 SHALL provide parameter: PRICE, default 15, product price in units; a multiple of 5 and greater than 0.
REQ-002 SHALL provide parameter: MAX_CREDIT, default 40, highest credit the block will hold; must be at least PRICE+20.
REQ-003 SHALL provide parameter: CREDIT_W, default 6, credit/change width; 2**CREDIT_W must be greater than MAX_CREDIT.
REQ-004 SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL provide port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide port: coin5  input  1  5-unit coin inserted this cycle.
REQ-007 SHALL provide port: coin10  input  1  10-unit coin inserted this cycle.
REQ-008 SHALL provide port: coin25  input  1  25-unit coin inserted this cycle.
REQ-009 SHALL provide port: cancel  input  1  customer abort; return all credit.
REQ-010 SHALL provide port: change_ack  input  1  change mechanism has paid out change_amt.
REQ-011 SHALL provide port: dispense  output  1  one-cycle product-release pulse.
REQ-012 SHALL provide port: change_valid  output  1  change_amt is valid and awaiting change_ack.
REQ-013 SHALL provide port: change_amt  output  CREDIT_W  change owed; 0 when change_valid=0.
REQ-014 SHALL provide port: credit  output  CREDIT_W  current credit register.
REQ-015 SHALL provide port: coin_reject  output  1  registered one-cycle pulse; the coin offered the previous cycle was not accepted.

Function
REQ-016 SHALL implement four states: IDLE (credit=0), CREDIT (0<credit<PRICE), VEND, CHANGE.
REQ-017 SHALL drive outputs as follows: dispense=(state==VEND); change_valid=(state==CHANGE); change_amt=credit in CHANGE, else 0; credit=credit register.
REQ-018 SHALL accept a coin only in IDLE or CREDIT, only when exactly one of coin5/coin10/coin25 is high, cancel is low, and credit+value<=MAX_CREDIT; an accepted coin adds its value to credit at that edge.
REQ-019 SHALL, for any coin input high that is not accepted (multiple coins, cancel asserted, VEND/CHANGE state, or overflow), leave credit unchanged and set coin_reject=1 for exactly the next cycle.
REQ-020 SHALL transition IDLE/CREDIT->VEND on the edge that accepts a coin making credit>=PRICE; otherwise IDLE->CREDIT on any accepted coin.
REQ-021 SHALL hold VEND for exactly one cycle (dispense=1, credit shows the full sum), then at the next edge set credit<=credit-PRICE and go to CHANGE if the remainder is greater than 0, else to IDLE.
REQ-022 SHALL, on cancel in CREDIT, go to CHANGE with credit unchanged; cancel SHALL be ignored in IDLE, VEND and CHANGE.
REQ-023 SHALL hold CHANGE with change_amt stable until change_ack=1, then at that edge set credit<=0 and go to IDLE; change_ack outside CHANGE SHALL be ignored.
REQ-024 SHALL produce no arithmetic wrap: credit never exceeds MAX_CREDIT and is never negative.
REQ-025 SHALL produce at most one dispense pulse per VEND entry; back-to-back purchases require a return through IDLE.

Reset
REQ-026 SHALL, on rst_n=0 at any time (including mid-VEND or mid-CHANGE), immediately clear state to IDLE, credit to 0, coin_reject to 0, and all outputs to 0, without waiting for a clock edge.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification (PRICE=15, MAX_CREDIT=40, CREDIT_W=6)
REQ-028 SHALL verify: reset asserted mid-operation -> all outputs are 0 asynchronously; after release, state is IDLE with credit=0.
REQ-029 SHALL verify: coin5 at cycle 1, coin10 at cycle 2 -> credit=5, then 15; dispense=1 in cycle 3 only; credit=0 and change_valid=0 from cycle 4.
REQ-030 SHALL verify: coin25 in IDLE -> VEND with credit=25 and dispense=1; next cycle CHANGE with change_amt=10, held for 3 cycles with no ack; change_ack -> IDLE with credit=0.
REQ-031 SHALL verify: coin10 then cancel -> CHANGE with change_amt=10 and no dispense; ack -> IDLE.
REQ-032 SHALL verify each of the following gives coin_reject=1 for one cycle with credit unchanged: coin5+coin10 together in IDLE; coin10 during CHANGE; coin5 together with cancel in CREDIT (cancel honoured).
REQ-033 SHALL verify: change_ack and cancel pulsed in IDLE -> no state change and all outputs stay 0.
